// File: rtl/mem_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_if
// Bus between the MEM-stage controller and a multi-cycle data memory with a
// Stall/Done/Err/CacheHit handshake.
//   master (controller): drives mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump;
//                        receives mem_rdata, mem_done, mem_stall, mem_err, mem_hit
//   slave  (memory)    : the mirror image
// DATA_W / ADDR_W must match the parameters of the controller that uses it.
// -----------------------------------------------------------------------------
interface mem_stage_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_dump;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_stall;
    logic              mem_err;
    logic              mem_hit;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump,
        input  mem_rdata, mem_done, mem_stall, mem_err, mem_hit
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_dump,
        output mem_rdata, mem_done, mem_stall, mem_err, mem_hit
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage controller: issues loads/stores to a multi-cycle data memory,
// stalls the pipeline until the memory reports done, registers load data,
// flags unaligned / conflicting / timed-out / memory-reported errors (sticky),
// and keeps saturating access and hit counters.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   aluOutput, writeData  address / store data from EX/MEM
//   memRead, memWrite     load / store request
//   dump                  createdump request, forwarded as mem_dump
//   readData              registered load data
//   stall_out             freezes IF, ID, EX and MEM
//   done_out              one-cycle completion pulse (RESP state)
//   err_out               sticky error flag, cleared only by rst
//   access_cnt, hit_cnt   saturating performance counters
//   bus                   memory side (mem_stage_ctrl_if.master)
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 63,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] aluOutput,
    input  logic [DATA_W-1:0] writeData,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              dump,
    output logic [DATA_W-1:0] readData,
    output logic              stall_out,
    output logic              done_out,
    output logic              err_out,
    output logic [CNT_W-1:0]  access_cnt,
    output logic [CNT_W-1:0]  hit_cnt,
    mem_stage_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Byte-offset bits that must be zero; all-zero mask for DATA_W=8.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(DATA_W / 8 - 1);
    // BUSY cycles are counted from 0, so the last permitted one holds TIMEOUT-1.
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rd_r;
    logic              wr_r;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic [DATA_W-1:0] read_data_r;
    logic              done_r;
    logic              err_r;
    logic [CNT_W-1:0]  access_cnt_r;
    logic [CNT_W-1:0]  hit_cnt_r;

    logic              req_s;
    logic              bad_req_s;
    logic              issue_s;
    logic              capture_s;
    logic              capture_rd_s;
    logic              tmo_hit_s;
    logic              rd_s;
    logic              wr_s;
    logic              stall_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;

    // mem_stall is informational only and never steers control.
    logic              unused_s;
    assign unused_s = bus.mem_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Request classification and completion / timeout detection.
    always_comb begin
        req_s        = memRead | memWrite;
        bad_req_s    = 1'b0;
        issue_s      = 1'b0;
        capture_s    = 1'b0;
        capture_rd_s = memRead;
        tmo_hit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if ((memRead & memWrite) || ((aluOutput & ALIGN_MASK) != '0)) begin
                        bad_req_s = 1'b1;
                    end else begin
                        issue_s = 1'b1;
                    end
                end else begin
                    bad_req_s = 1'b0;
                end
                capture_s    = issue_s & bus.mem_done;
                capture_rd_s = memRead;
            end
            BUSY: begin
                capture_s    = bus.mem_done;
                capture_rd_s = rd_r;
                tmo_hit_s    = ~bus.mem_done & (tmo_cnt_r == TMO_LAST);
            end
            RESP: begin
                capture_s = 1'b0;
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
    end

    // Memory-side strobes, address/data mux and stall; BUSY uses issue-time copies.
    always_comb begin
        rd_s    = 1'b0;
        wr_s    = 1'b0;
        stall_s = 1'b0;
        addr_s  = aluOutput;
        wdata_s = writeData;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    rd_s    = memRead;
                    wr_s    = memWrite;
                    stall_s = 1'b1;
                end else begin
                    rd_s    = 1'b0;
                    wr_s    = 1'b0;
                    stall_s = 1'b0;
                end
            end
            BUSY: begin
                rd_s    = rd_r;
                wr_s    = wr_r;
                stall_s = 1'b1;
                addr_s  = addr_r;
                wdata_s = wdata_r;
            end
            RESP: begin
                stall_s = 1'b0;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
    end

    // Strobes and stall are forced low while rst is high, without waiting for an edge.
    assign bus.mem_rd    = rd_s & ~rst;
    assign bus.mem_wr    = wr_s & ~rst;
    assign stall_out     = stall_s & ~rst;
    assign bus.mem_addr  = addr_s;
    assign bus.mem_wdata = wdata_s;
    assign bus.mem_dump  = dump;

    assign readData   = read_data_r;
    assign done_out   = done_r;
    assign err_out    = err_r;
    assign access_cnt = access_cnt_r;
    assign hit_cnt    = hit_cnt_r;

    // Controller FSM with issue-time copies, result capture, error and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            addr_r       <= '0;
            wdata_r      <= '0;
            rd_r         <= 1'b0;
            wr_r         <= 1'b0;
            tmo_cnt_r    <= '0;
            read_data_r  <= '0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            access_cnt_r <= '0;
            hit_cnt_r    <= '0;
        end else begin
            done_r <= 1'b0;

            if (bus.mem_err || bad_req_s || tmo_hit_s) begin
                err_r <= 1'b1;
            end

            if (capture_s) begin
                if (capture_rd_s) begin
                    read_data_r <= bus.mem_rdata;
                end
                access_cnt_r <= sat_inc(access_cnt_r);
                if (bus.mem_hit) begin
                    hit_cnt_r <= sat_inc(hit_cnt_r);
                end
            end

            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        addr_r    <= aluOutput;
                        wdata_r   <= writeData;
                        rd_r      <= memRead;
                        wr_r      <= memWrite;
                        tmo_cnt_r <= '0;
                        if (bus.mem_done) begin
                            state_r <= RESP;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_done) begin
                        state_r <= RESP;
                        done_r  <= 1'b1;
                        rd_r    <= 1'b0;
                        wr_r    <= 1'b0;
                    end else if (tmo_hit_s) begin
                        state_r <= IDLE;
                        rd_r    <= 1'b0;
                        wr_r    <= 1'b0;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                RESP: begin
                    // The MEM-stage instruction advances here; nothing is re-issued.
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Two controllers share all stimulus: dut0 with default parameters and dut1
// with CNT_W=4 to exercise counter saturation. Expected completions are
// pushed to a queue when an access is issued; a monitor pops and compares
// whenever done_out pulses. Directed checks cover stall length, strobes,
// errors, timeout and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] aluOutput = 16'h0000;
    logic [15:0] writeData = 16'h0000;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic        dump = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_done = 1'b0;
    logic        mem_err = 1'b0;
    logic        mem_hit = 1'b0;

    logic [15:0] readData0, readData1;
    logic        stall0, stall1, done0, done1, err0, err1;
    logic [15:0] acc0, hit0;
    logic [3:0]  acc1, hit1;

    mem_stage_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
    mem_stage_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

    assign bus0.mem_rdata = mem_rdata;
    assign bus0.mem_done  = mem_done;
    assign bus0.mem_stall = 1'b0;
    assign bus0.mem_err   = mem_err;
    assign bus0.mem_hit   = mem_hit;
    assign bus1.mem_rdata = mem_rdata;
    assign bus1.mem_done  = mem_done;
    assign bus1.mem_stall = 1'b0;
    assign bus1.mem_err   = mem_err;
    assign bus1.mem_hit   = mem_hit;

    mem_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(63), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .aluOutput(aluOutput), .writeData(writeData),
        .memRead(memRead), .memWrite(memWrite), .dump(dump),
        .readData(readData0), .stall_out(stall0), .done_out(done0), .err_out(err0),
        .access_cnt(acc0), .hit_cnt(hit0), .bus(bus0)
    );

    mem_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(63), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .aluOutput(aluOutput), .writeData(writeData),
        .memRead(memRead), .memWrite(memWrite), .dump(dump),
        .readData(readData1), .stall_out(stall1), .done_out(done1), .err_out(err1),
        .access_cnt(acc1), .hit_cnt(hit1), .bus(bus1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rdata;
        logic [15:0] acc;
        logic [15:0] hit;
        logic [3:0]  acc4;
        logic [3:0]  hit4;
    } exp_t;

    exp_t sb[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model of the completed-access state.
    logic [15:0] m_rdata = 16'h0000;
    logic [15:0] m_acc   = 16'h0000;
    logic [15:0] m_hit   = 16'h0000;
    logic [3:0]  m_acc4  = 4'h0;
    logic [3:0]  m_hit4  = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] sat4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done0) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done_out=1 expected no completion at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_readData", {16'h0, readData0}, {16'h0, e.rdata});
                chk("resp_access_cnt", {16'h0, acc0}, {16'h0, e.acc});
                chk("resp_hit_cnt", {16'h0, hit0}, {16'h0, e.hit});
                chk("resp_stall_low", {31'h0, stall0}, 32'd0);
                chk("resp_done_w4", {31'h0, done1}, 32'd1);
                chk("resp_access_cnt_w4", {28'h0, acc1}, {28'h0, e.acc4});
                chk("resp_hit_cnt_w4", {28'h0, hit1}, {28'h0, e.hit4});
            end
        end
    end

    task automatic model_clear();
        m_rdata = 16'h0000;
        m_acc   = 16'h0000;
        m_hit   = 16'h0000;
        m_acc4  = 4'h0;
        m_hit4  = 4'h0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        memRead = 1'b0;
        memWrite = 1'b0;
        mem_done = 1'b0;
        mem_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One access: issue, lat BUSY cycles, mem_done in the last of them, then RESP.
    // Inputs are scrambled after issue to show the held copies are used.
    task automatic run_access(input logic is_rd, input logic [15:0] addr, input logic [15:0] wd,
                              input int lat, input logic [15:0] rdat, input logic hit,
                              input string tag);
        int stall_n;
        int strobe_n;
        int bus_bad;
        stall_n = 0;
        strobe_n = 0;
        bus_bad = 0;
        if (is_rd) m_rdata = rdat;
        m_acc  = m_acc + 16'd1;
        m_acc4 = sat4(m_acc4);
        if (hit) begin
            m_hit  = m_hit + 16'd1;
            m_hit4 = sat4(m_hit4);
        end
        sb.push_back('{m_rdata, m_acc, m_hit, m_acc4, m_hit4});
        memRead = is_rd;
        memWrite = ~is_rd;
        aluOutput = addr;
        writeData = wd;
        mem_rdata = rdat;
        mem_hit = hit;
        for (int c = 0; c <= lat; c++) begin
            mem_done = (c == lat);
            @(negedge clk);
            if (stall0) stall_n++;
            if (is_rd ? bus0.mem_rd : bus0.mem_wr) strobe_n++;
            if (bus0.mem_addr !== addr || bus1.mem_addr !== addr) bus_bad++;
            if (!is_rd && bus0.mem_wdata !== wd) bus_bad++;
            @(posedge clk);
            #1;
            memRead = 1'b0;
            memWrite = 1'b0;
            aluOutput = addr + 16'h0100;
            writeData = ~wd;
        end
        mem_done = 1'b0;
        mem_hit = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_stall_cycles"}, stall_n, lat + 1);
        chk({tag, "_strobe_cycles"}, strobe_n, lat + 1);
        chk({tag, "_held_addr_data"}, bus_bad, 0);
    endtask

    initial begin
        int rd_n;
        int st_n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_readData", {16'h0, readData0}, 32'd0);
        chk("rst_done", {31'h0, done0}, 32'd0);
        chk("rst_err", {31'h0, err0}, 32'd0);
        chk("rst_access_cnt", {16'h0, acc0}, 32'd0);
        chk("rst_hit_cnt", {16'h0, hit0}, 32'd0);
        chk("rst_stall", {31'h0, stall0}, 32'd0);
        chk("rst_mem_rd", {31'h0, bus0.mem_rd}, 32'd0);
        dump = 1'b1;
        #1;
        chk("dump_passthru", {31'h0, bus0.mem_dump}, 32'd1);
        dump = 1'b0;
        @(posedge clk);
        #1;

        // Aligned load, done 3 cycles after issue, then zero-wait store hit
        run_access(1'b1, 16'h0010, 16'h0000, 3, 16'hBEEF, 1'b0, "load_lat3");
        run_access(1'b0, 16'h0020, 16'h1234, 0, 16'hDEAD, 1'b1, "store_lat0");
        chk("pre_tmo_err", {31'h0, err0}, 32'd0);

        // Timeout: mem_done never comes
        memRead = 1'b1;
        aluOutput = 16'h0040;
        rd_n = 0;
        st_n = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (bus0.mem_rd) rd_n++;
            if (stall0) st_n++;
            @(posedge clk);
            #1;
            memRead = 1'b0;
        end
        chk("tmo_rd_cycles", rd_n, 64);
        chk("tmo_stall_cycles", st_n, 64);
        chk("tmo_err", {31'h0, err0}, 32'd1);
        chk("tmo_access_cnt", {16'h0, acc0}, 32'd2);
        chk("tmo_hit_cnt", {16'h0, hit0}, 32'd1);

        // Asynchronous reset mid-BUSY
        memRead = 1'b1;
        aluOutput = 16'h0080;
        @(posedge clk);
        #1;
        memRead = 1'b0;
        @(posedge clk);
        #3;
        chk("busy_rd_before_rst", {31'h0, bus0.mem_rd}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_mem_rd", {31'h0, bus0.mem_rd}, 32'd0);
        chk("arst_stall", {31'h0, stall0}, 32'd0);
        chk("arst_err", {31'h0, err0}, 32'd0);
        chk("arst_access_cnt", {16'h0, acc0}, 32'd0);
        chk("arst_hit_cnt", {16'h0, hit0}, 32'd0);
        chk("arst_readData", {16'h0, readData0}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        run_access(1'b1, 16'h0030, 16'h0000, 1, 16'h5A5A, 1'b0, "load_after_rst");
        chk("post_rst_err", {31'h0, err0}, 32'd0);

        // Unaligned load: no access, sticky error
        memRead = 1'b1;
        aluOutput = 16'h0011;
        @(negedge clk);
        chk("unal_mem_rd", {31'h0, bus0.mem_rd}, 32'd0);
        chk("unal_stall", {31'h0, stall0}, 32'd0);
        @(posedge clk);
        #1;
        memRead = 1'b0;
        aluOutput = 16'h0000;
        @(negedge clk);
        chk("unal_err", {31'h0, err0}, 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("unal_err_sticky", {31'h0, err0}, 32'd1);
        chk("unal_access_cnt", {16'h0, acc0}, 32'd1);

        // Conflicting read+write request
        apply_reset();
        memRead = 1'b1;
        memWrite = 1'b1;
        aluOutput = 16'h0050;
        @(negedge clk);
        chk("conf_mem_rd", {31'h0, bus0.mem_rd}, 32'd0);
        chk("conf_mem_wr", {31'h0, bus0.mem_wr}, 32'd0);
        chk("conf_stall", {31'h0, stall0}, 32'd0);
        @(posedge clk);
        #1;
        memRead = 1'b0;
        memWrite = 1'b0;
        @(negedge clk);
        chk("conf_err", {31'h0, err0}, 32'd1);

        // Memory-reported error while idle
        apply_reset();
        @(negedge clk);
        chk("merr_err_before", {31'h0, err0}, 32'd0);
        mem_err = 1'b1;
        @(posedge clk);
        #1;
        mem_err = 1'b0;
        @(negedge clk);
        chk("merr_err", {31'h0, err0}, 32'd1);

        // 17 back-to-back hit loads: the 4-bit counters stick at 0xF
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            run_access(1'b1, 16'h0100 + 16'(i * 2), 16'h0000, i % 2,
                       16'hA000 + 16'(i), 1'b1, "sat_load");
        end
        @(negedge clk);
        chk("sat_access_cnt_w4", {28'h0, acc1}, 32'hF);
        chk("sat_hit_cnt_w4", {28'h0, hit1}, 32'hF);
        chk("sat_access_cnt_w16", {16'h0, acc0}, 32'd17);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Parametrised MEM-stage controller between the pipeline's MEM stage and a multi-cycle data memory with a Stall/Done/Err/CacheHit handshake, such as stallmem.
- Issues load/store requests and holds the pipeline stalled until the memory completes.
- Registers load data and detects unaligned, conflicting and timed-out accesses.
- Keeps saturating access and hit counters for the performance dump.

Parameters:
DATA_W, 16, data width in bits; a power of two, at least 8.
ADDR_W, 16, byte address width.
TIMEOUT, 63, maximum cycles spent in BUSY before the access is aborted.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
aluOutput  in  ADDR_W  byte address from EX/MEM
writeData  in  DATA_W  store data
memRead  in  1  load request
memWrite  in  1  store request
dump  in  1  createdump request, passed to the memory
readData  out  DATA_W  registered load data
stall_out  out  1  freezes the IF, ID, EX and MEM stages
done_out  out  1  one-cycle completion pulse
err_out  out  1  sticky error flag
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_dump  out  1  equals dump
mem_rdata  in  DATA_W  memory read data
mem_done  in  1  memory completion
mem_stall  in  1  memory busy; informational only
mem_err  in  1  memory error
mem_hit  in  1  cache hit, sampled with mem_done
access_cnt  out  CNT_W  completed accesses, saturating
hit_cnt  out  CNT_W  completed accesses with mem_hit=1, saturating

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - readData, done_out, err_out, access_cnt, hit_cnt and the timeout counter all reset to 0.
  - mem_rd and mem_wr drop to 0 immediately, including when reset arrives mid-access.
- Alignment: an access is aligned when aluOutput[log2(DATA_W/8)-1:0]==0. For DATA_W=8 every address is aligned.
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request (memRead=memWrite=0): stall_out=0, strobes low.
  - memRead=memWrite=1, or an unaligned request: no memory access is made, err_out set next edge, stall_out=0, state stays IDLE.
  - Valid request:
    - mem_rd/mem_wr follow memRead/memWrite combinationally; mem_addr=aluOutput, mem_wdata=writeData; stall_out=1.
    - mem_done=1 in the same cycle (zero-wait hit): capture the result and go to RESP.
    - Otherwise go to BUSY and clear the timeout counter.
- BUSY:
  - mem_rd/mem_wr and the address/data are held from registered copies taken at issue, so later changes on the input ports are ignored.
  - stall_out=1; the timeout counter increments each cycle.
  - On mem_done: capture the result, go to RESP.
  - When the counter reaches TIMEOUT without mem_done: drop the strobes, set err_out, go to IDLE. The access is not counted.
- Capture: on mem_done for a read, readData<=mem_rdata; for a write, readData keeps its value. access_cnt+=1, and hit_cnt+=1 if mem_hit. Both counters saturate at all-ones.
- RESP:
  - stall_out=0, done_out=1 for exactly this cycle, strobes low.
  - Next state is IDLE unconditionally. The MEM-stage instruction advances at this edge, so requests present during RESP are not re-issued.
- Memory error: mem_err=1 in any cycle sets err_out. err_out clears only on rst.
- Latency:
  - Load result appears on readData the cycle after mem_done.
  - stall_out covers every cycle from issue through the cycle of mem_done.
  - Minimum occupancy is 2 cycles: issue and RESP.
- mem_stall does not affect control.

Test Plan:
- Aligned load, addr 0x0010, mem_done 3 cycles after issue with mem_rdata=0xBEEF, hit=0 -> stall_out high for 4 cycles; RESP cycle done_out=1, readData=0xBEEF, access_cnt=1, hit_cnt=0.
- Store, addr 0x0020, data 0x1234, mem_done=1 with hit=1 in the issue cycle -> mem_wr high for exactly 1 cycle, stall_out high 1 cycle, next cycle done_out=1, readData unchanged, hit_cnt=1.
- Load to addr 0x0011 -> mem_rd never asserts, stall_out=0, err_out=1 after one edge and still 1 ten cycles later.
- mem_done never asserts with TIMEOUT=63 -> mem_rd held 64 cycles (issue plus 63 BUSY), then drops; err_out=1, state IDLE, done_out never pulses, access_cnt unchanged.
- rst asserted mid-BUSY, between edges -> mem_rd, stall_out, err_out and the counters go to 0 without waiting for a clock edge; the next aligned load completes normally.
- CNT_W=4, 17 back-to-back hit loads -> access_cnt and hit_cnt stick at 0xF; inputs changed during BUSY do not alter mem_addr.
